irq_request_reg: RTL and testbench

//  Clocked, parametrised interrupt request register (IRR) with priority pick for the 8259-style PIC.
//  - Synchronises NUM_IRQ asynchronous request lines.
//  - Latches each line as edge- or level-triggered, selected per channel.
//  - Applies the mask and resolves the highest-priority pending request with rotating priority.
//  - Clears the served edge request on the CPU acknowledge strobe.
//  - Sits between the external IR pins and the ISR/control logic.

---
 rtl/irq_request_reg_if.sv | 25 ++
 rtl/irq_request_reg.sv | 124 ++++++++++++
 tb/tb_irq_request_reg.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/irq_request_reg_if.sv
// Request-register bus: pin/config/ack inputs and the IRR/priority outputs of the PIC front end.
interface irq_request_reg_if #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = 3
);
    logic [NUM_IRQ-1:0] irq_lines;
    logic [NUM_IRQ-1:0] trig_mode;
    logic [NUM_IRQ-1:0] imr;
    logic [IDX_W-1:0]   prio_base;
    logic               ack;
    logic [NUM_IRQ-1:0] irr;
    logic               int_req;
    logic [IDX_W-1:0]   int_idx;
    logic               spurious;

    modport master (
        output irq_lines, trig_mode, imr, prio_base, ack,
        input  irr, int_req, int_idx, spurious
    );

    modport slave (
        input  irq_lines, trig_mode, imr, prio_base, ack,
        output irr, int_req, int_idx, spurious
    );
endinterface

// File: rtl/irq_request_reg.sv
// 8259-style interrupt request register: per-line sync, edge/level latch, mask and
// rotating-priority pick with ack handshake.
module irq_request_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic warm_i,
    input  logic line_i,
    input  logic level_i,
    input  logic clr_i,
    output logic irr_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic prev_q, mode_q, armed_q, irr_q, irr_d;
    logic sync, rise;

    assign sync = sync_q[SYNC_STAGES-1];
    // A line only counts as rising once it has been seen low after reset,
    // so a pin held high through reset cannot re-request.
    assign rise = sync & ~prev_q & armed_q;

    always_comb begin
        irr_d = irr_q;
        if (level_i != mode_q) irr_d = 1'b0;
        else if (level_i)      irr_d = sync;
        else if (rise)         irr_d = 1'b1;
        else if (!sync)        irr_d = 1'b0;
        else if (clr_i)        irr_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            mode_q  <= 1'b0;
            armed_q <= 1'b0;
            irr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], line_i};
            prev_q  <= sync;
            mode_q  <= level_i;
            armed_q <= armed_q | (warm_i & ~sync);
            irr_q   <= irr_d;
        end
    end

    assign irr_o = irr_q;
endmodule

module irq_request_reg #(
    parameter int NUM_IRQ     = 8,
    parameter int IDX_W       = 3,
    parameter int SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             rst,
    irq_request_reg_if.slave bus
);
    logic [SYNC_STAGES-1:0]   warm_q;
    logic [NUM_IRQ-1:0]       irr, clr, req;
    logic [2*NUM_IRQ-1:0]     rot;
    logic [IDX_W-1:0]         base, int_idx_q, int_idx_d;
    logic                     int_req_q, int_req_d, spurious_q, spurious_d;
    logic                     ack_hit, found;
    int                       w;

    assign ack_hit = bus.ack & int_req_q;

    // Sync chains hold reset zeros until they have refilled with real samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) warm_q <= '0;
        else     warm_q <= {warm_q[SYNC_STAGES-2:0], 1'b1};
    end

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_lane
        assign clr[g] = ack_hit && (int_idx_q == IDX_W'(g));
        irq_request_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .warm_i (warm_q[SYNC_STAGES-1]),
            .line_i (bus.irq_lines[g]),
            .level_i(bus.trig_mode[g]),
            .clr_i  (clr[g]),
            .irr_o  (irr[g])
        );
    end

    // Rotate so prio_base sits at bit 0; the lowest set bit is the winner.
    always_comb begin
        req       = irr & ~bus.imr;
        base      = (int'(bus.prio_base) < NUM_IRQ) ? bus.prio_base : '0;
        rot       = {req, req} >> base;
        found     = 1'b0;
        w         = 0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                w     = int'(base) + k;
            end
        end
        if (w >= NUM_IRQ) w = w - NUM_IRQ;
        int_idx_d  = IDX_W'(w);
        int_req_d  = found & ~ack_hit;
        spurious_d = bus.ack & ~int_req_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_req_q  <= 1'b0;
            int_idx_q  <= '0;
            spurious_q <= 1'b0;
        end else begin
            int_req_q  <= int_req_d;
            int_idx_q  <= int_idx_d;
            spurious_q <= spurious_d;
        end
    end

    assign bus.irr      = irr;
    assign bus.int_req  = int_req_q;
    assign bus.int_idx  = int_idx_q;
    assign bus.spurious = spurious_q;
endmodule

// File: tb/tb_irq_request_reg.sv
// Directed bench for irq_request_reg: latency, priority rotation, level/ack, mask,
// spurious ack, set-over-clear and reset behaviour.
module tb_irq_request_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    irq_request_reg_if #(.NUM_IRQ(8), .IDX_W(3)) bus ();

    irq_request_reg #(.NUM_IRQ(8), .IDX_W(3), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

    initial begin
        bus.irq_lines = '0;
        bus.trig_mode = '0;
        bus.imr       = '0;
        bus.prio_base = '0;
        bus.ack       = 1'b0;
        tick(2);
        chk("rst_irr", 32'(bus.irr), 0);
        chk("rst_int_req", 32'(bus.int_req), 0);
        chk("rst_int_idx", 32'(bus.int_idx), 0);
        chk("rst_spurious", 32'(bus.spurious), 0);
        rst = 1'b0;
        tick(3);
        chk("idle_irr", 32'(bus.irr), 0);

        // 1: edge ch3 latency and ack
        bus.irq_lines = 8'h08;
        tick(2);
        chk("t1_irr_e2", 32'(bus.irr), 0);
        tick();
        chk("t1_irr_e3", 32'(bus.irr), 32'h08);
        chk("t1_req_e3", 32'(bus.int_req), 0);
        tick();
        chk("t1_req_e4", 32'(bus.int_req), 1);
        chk("t1_idx_e4", 32'(bus.int_idx), 3);
        tick();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("t1_req_ack", 32'(bus.int_req), 0);
        chk("t1_irr_ack", 32'(bus.irr), 0);
        bus.irq_lines = '0;
        tick(3);
        chk("t1_req_idle", 32'(bus.int_req), 0);

        // 2: rotating priority
        bus.irq_lines = 8'h24;
        tick(3);
        chk("t2_irr", 32'(bus.irr), 32'h24);
        tick();
        chk("t2_req", 32'(bus.int_req), 1);
        chk("t2_idx_b0", 32'(bus.int_idx), 2);
        bus.prio_base = 3'd4;
        tick();
        chk("t2_idx_b4", 32'(bus.int_idx), 5);
        bus.prio_base = 3'd6;
        tick();
        chk("t2_idx_b6", 32'(bus.int_idx), 2);
        bus.irq_lines = '0;
        bus.prio_base = '0;
        tick(4);
        chk("t2_irr_clr", 32'(bus.irr), 0);
        chk("t2_req_clr", 32'(bus.int_req), 0);

        // 3: level ch1
        bus.trig_mode = 8'h02;
        tick();
        bus.irq_lines = 8'h02;
        tick(3);
        chk("t3_irr", 32'(bus.irr), 32'h02);
        tick();
        chk("t3_req", 32'(bus.int_req), 1);
        chk("t3_idx", 32'(bus.int_idx), 1);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("t3_req_ack", 32'(bus.int_req), 0);
        chk("t3_irr_ack", 32'(bus.irr), 32'h02);
        tick();
        chk("t3_req_again", 32'(bus.int_req), 1);
        chk("t3_idx_again", 32'(bus.int_idx), 1);
        bus.irq_lines = '0;
        tick(2);
        chk("t3_irr_e2", 32'(bus.irr), 32'h02);
        tick();
        chk("t3_irr_e3", 32'(bus.irr), 0);
        tick();
        chk("t3_req_low", 32'(bus.int_req), 0);
        bus.trig_mode = '0;
        tick();

        // 4: mask
        bus.imr       = 8'h10;
        bus.irq_lines = 8'h10;
        tick(3);
        chk("t4_irr", 32'(bus.irr), 32'h10);
        tick();
        chk("t4_req_masked", 32'(bus.int_req), 0);
        bus.imr = '0;
        tick();
        chk("t4_req_unmask", 32'(bus.int_req), 1);
        chk("t4_idx", 32'(bus.int_idx), 4);
        bus.irq_lines = '0;
        tick(4);
        chk("t4_req_clr", 32'(bus.int_req), 0);
        chk("t4_irr_clr", 32'(bus.irr), 0);

        // 5: spurious ack, then set wins over ack clear
        chk("t5_pre_req", 32'(bus.int_req), 0);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("t5_spur", 32'(bus.spurious), 1);
        chk("t5_spur_irr", 32'(bus.irr), 0);
        tick();
        chk("t5_spur_off", 32'(bus.spurious), 0);
        bus.irq_lines = 8'h01;
        tick(4);
        chk("t5_req0", 32'(bus.int_req), 1);
        chk("t5_idx0", 32'(bus.int_idx), 0);
        bus.irq_lines = '0;
        tick();
        bus.irq_lines = 8'h01;
        tick(2);
        chk("t5_withdraw", 32'(bus.irr), 0);
        chk("t5_req_stale", 32'(bus.int_req), 1);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("t5_set_wins", 32'(bus.irr), 32'h01);
        chk("t5_req_acked", 32'(bus.int_req), 0);
        tick();
        chk("t5_req_back", 32'(bus.int_req), 1);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("t5_ack_clr", 32'(bus.irr), 0);
        bus.irq_lines = '0;
        tick(3);

        // 6: reset mid-request, line held high
        bus.irq_lines = 8'h80;
        tick(4);
        chk("t6_req", 32'(bus.int_req), 1);
        chk("t6_idx", 32'(bus.int_idx), 7);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_irr", 32'(bus.irr), 0);
        chk("t6_rst_req", 32'(bus.int_req), 0);
        chk("t6_rst_idx", 32'(bus.int_idx), 0);
        tick();
        rst = 1'b0;
        tick(6);
        chk("t6_hold_irr", 32'(bus.irr), 0);
        chk("t6_hold_req", 32'(bus.int_req), 0);
        bus.irq_lines = '0;
        tick(3);
        chk("t6_low_irr", 32'(bus.irr), 0);
        bus.irq_lines = 8'h80;
        tick(3);
        chk("t6_new_irr", 32'(bus.irr), 32'h80);
        tick();
        chk("t6_new_req", 32'(bus.int_req), 1);
        chk("t6_new_idx", 32'(bus.int_idx), 7);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
